// File: rtl/contador_modulo_param.sv
// Cascaded modulo-N up/down counter: DIGITS digits of WIDTH bits each, counting 0..MODULUS-1,
// with synchronous parallel load, combinational terminal count and a registered wrap/blocked flag.
module contador_modulo_param #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int DIGITS   = 2,
   parameter int SATURATE = 0
) (
   input  logic                      clk,
   input  logic                      clear,
   input  logic                      en,
   input  logic                      up,
   input  logic                      load,
   input  logic [DIGITS*WIDTH-1:0]   load_val,
   output logic [DIGITS*WIDTH-1:0]   q,
   output logic                      tc,
   output logic                      wrap
);

   localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] d);
      if ({1'b0, d} >= LP_MOD) return LP_MAX;
      return d;
   endfunction

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d, input logic dir);
      if (dir) return (d == LP_MAX) ? '0 : d + 1'b1;
      return (d == '0) ? LP_MAX : d - 1'b1;
   endfunction

   logic [DIGITS*WIDTH-1:0] r_q;
   logic                    r_wrap;
   logic [DIGITS*WIDTH-1:0] w_q_cnt;
   logic [DIGITS*WIDTH-1:0] w_q_load;
   logic                    w_all_ext;
   logic                    w_tc;

   // Ripple the "all lower digits at their extreme" condition up the digit chain.
   always_comb begin : p_next
      logic v_c;
      v_c      = 1'b1;
      w_q_cnt  = r_q;
      w_q_load = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v_c) w_q_cnt[i*WIDTH +: WIDTH] = f_step(r_q[i*WIDTH +: WIDTH], up);
         v_c = v_c & (up ? (r_q[i*WIDTH +: WIDTH] == LP_MAX) : (r_q[i*WIDTH +: WIDTH] == '0));
         w_q_load[i*WIDTH +: WIDTH] = f_clamp(load_val[i*WIDTH +: WIDTH]);
      end
      w_all_ext = v_c;
   end

   assign w_tc = en & w_all_ext;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
      end else if (load) begin
         r_q    <= w_q_load;
         r_wrap <= 1'b0;
      end else if (en) begin
         // In saturating mode a count at the extreme is blocked but still flagged.
         if (!((SATURATE != 0) && w_tc)) r_q <= w_q_cnt;
         r_wrap <= w_tc;
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign q    = r_q;
   assign tc   = w_tc;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_contador_modulo_param.sv
// Directed bench for contador_modulo_param: wrapping BCD pair, saturating BCD pair,
// and two single-digit modulo-6 instances cascaded through tc.
module tb_contador_modulo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Wrapping instance (defaults)
   logic       a_clear, a_en, a_up, a_load;
   logic [7:0] a_lv, a_q;
   logic       a_tc, a_wrap;
   contador_modulo_param #(.WIDTH(4), .MODULUS(10), .DIGITS(2), .SATURATE(0)) u_a (
      .clk(clk), .clear(a_clear), .en(a_en), .up(a_up), .load(a_load),
      .load_val(a_lv), .q(a_q), .tc(a_tc), .wrap(a_wrap));

   // Saturating instance
   logic       b_clear, b_en, b_up, b_load;
   logic [7:0] b_lv, b_q;
   logic       b_tc, b_wrap;
   contador_modulo_param #(.WIDTH(4), .MODULUS(10), .DIGITS(2), .SATURATE(1)) u_b (
      .clk(clk), .clear(b_clear), .en(b_en), .up(b_up), .load(b_load),
      .load_val(b_lv), .q(b_q), .tc(b_tc), .wrap(b_wrap));

   // Cascaded modulo-6 pair
   logic       c_clear, c_en, c_up;
   logic [2:0] c_q1, c_q2;
   logic       c_tc1, c_tc2, c_w1, c_w2;
   contador_modulo_param #(.WIDTH(3), .MODULUS(6), .DIGITS(1), .SATURATE(0)) u_c1 (
      .clk(clk), .clear(c_clear), .en(c_en), .up(c_up), .load(1'b0),
      .load_val(3'd0), .q(c_q1), .tc(c_tc1), .wrap(c_w1));
   contador_modulo_param #(.WIDTH(3), .MODULUS(6), .DIGITS(1), .SATURATE(0)) u_c2 (
      .clk(clk), .clear(c_clear), .en(c_tc1), .up(c_up), .load(1'b0),
      .load_val(3'd0), .q(c_q2), .tc(c_tc2), .wrap(c_w2));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] bcd(input int c);
      return 8'(((c / 10) << 4) | (c % 10));
   endfunction

   int  cnt;
   logic prev_tc;

   initial begin
      a_clear = 1; a_en = 1; a_up = 1; a_load = 1; a_lv = 8'h55;
      b_clear = 1; b_en = 0; b_up = 1; b_load = 0; b_lv = 8'h00;
      c_clear = 1; c_en = 0; c_up = 1;
      tick();
      chk("reset_q", a_q, 8'h00);
      chk("reset_wrap", a_wrap, 1'b0);
      chk("reset_b_q", b_q, 8'h00);

      // Up count through the full range and wrap
      a_clear = 0; a_load = 0; a_en = 1; a_up = 1;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         #1 chk("up_tc", a_tc, (cnt == 99));
         prev_tc = (cnt == 99);
         tick();
         cnt = (cnt + 1) % 100;
         chk("up_q", a_q, bcd(cnt));
         chk("up_wrap", a_wrap, prev_tc);
      end
      a_en = 0;
      tick();
      chk("idle_wrap", a_wrap, 1'b0);
      chk("idle_q", a_q, 8'h00);

      // Down count from cleared state
      a_clear = 1; tick(); a_clear = 0;
      a_en = 1; a_up = 0; cnt = 0;
      for (int k = 0; k < 12; k++) begin
         #1 chk("dn_tc", a_tc, (cnt == 0));
         prev_tc = (cnt == 0);
         tick();
         cnt = (cnt + 99) % 100;
         chk("dn_q", a_q, bcd(cnt));
         chk("dn_wrap", a_wrap, prev_tc);
      end

      // Loads: clamping, priority over en, wrap cleared
      a_en = 0; a_load = 1; a_lv = 8'h3F; tick();
      chk("load_clamp_lo", a_q, 8'h39);
      a_lv = 8'hA7; tick();
      chk("load_clamp_hi", a_q, 8'h97);
      a_en = 1; a_up = 1; a_lv = 8'h99; tick();
      a_lv = 8'h52; tick();
      chk("load_over_en", a_q, 8'h52);
      chk("load_wrap0", a_wrap, 1'b0);

      // Direction change with no dead cycle, then hold
      a_lv = 8'h45; tick();
      a_load = 0; a_en = 1; a_up = 1; tick();
      chk("dir_up", a_q, 8'h46);
      a_up = 0; tick();
      chk("dir_dn", a_q, 8'h45);
      a_en = 0; tick();
      chk("hold_q", a_q, 8'h45);
      #1 chk("hold_tc", a_tc, 1'b0);

      // tc qualified by en and direction at 0x99
      a_load = 1; a_lv = 8'h99; tick(); a_load = 0;
      a_en = 0; a_up = 1; #1 chk("tc_en0", a_tc, 1'b0);
      a_en = 1; #1 chk("tc_up", a_tc, 1'b1);
      a_up = 0; #1 chk("tc_dn_at99", a_tc, 1'b0);
      a_en = 0;

      // Clear overrides load mid-load
      a_load = 1; a_lv = 8'h77; a_clear = 1; tick();
      chk("clear_over_load", a_q, 8'h00);
      a_load = 0; a_clear = 0;

      // Saturating instance
      b_clear = 0; b_load = 1; b_lv = 8'h99; tick();
      b_load = 0; b_en = 1; b_up = 1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("sat_tc", b_tc, 1'b1);
         tick();
         chk("sat_q", b_q, 8'h99);
         chk("sat_wrap", b_wrap, 1'b1);
      end
      b_up = 0; tick();
      chk("sat_dn_q", b_q, 8'h98);
      chk("sat_dn_wrap", b_wrap, 1'b0);
      b_load = 1; b_lv = 8'h00; tick(); b_load = 0;
      tick();
      chk("sat_bot_q", b_q, 8'h00);
      chk("sat_bot_wrap", b_wrap, 1'b1);
      b_en = 0;

      // Cascade of two modulo-6 digits counts 0..35
      c_clear = 0; c_en = 1; c_up = 1; cnt = 0;
      for (int k = 0; k < 38; k++) begin
         #1 chk("cas_tc", c_tc2, (cnt == 35));
         prev_tc = (cnt == 35);
         tick();
         cnt = (cnt + 1) % 36;
         chk("cas_val", 32'(c_q2) * 6 + 32'(c_q1), cnt);
         chk("cas_wrap", c_w2, prev_tc);
      end
      c_en = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/contador_modulo_param.md
CONTADOR_MODULO_PARAM -- requirements
Module: contador_modulo_param

Interface
REQ-001 Parameter: WIDTH, default 4, bits per digit.
REQ-002 Parameter: MODULUS, default 10, count states per digit; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter: DIGITS, default 2, number of cascaded digits.
REQ-004 Parameter: SATURATE, default 0; 0 = wrap at extremes, 1 = hold at extremes.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 clear  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable.
REQ-008 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_val  input  DIGITS*WIDTH  load data; digit i at bits [i*WIDTH +: WIDTH].
REQ-011 q  output  DIGITS*WIDTH  registered count; same digit packing as load_val.
REQ-012 tc  output  1  combinational terminal count.
REQ-013 wrap  output  1  registered one-cycle event flag.

Function
REQ-014 Per-edge priority SHALL be: clear > load > en; with none active, q and digit state hold.
REQ-015 Load SHALL write each digit from load_val, clamping any digit >= MODULUS to MODULUS-1.
REQ-016 Load SHALL NOT count in the same cycle, and SHALL drive wrap to 0 on the next cycle.
REQ-017 Count (en=1, load=0): digit 0 SHALL step by one modulo MODULUS each enabled cycle.
REQ-018 Digit i>0 SHALL step only when all lower digits sit at MODULUS-1 (up=1) or at 0 (up=0).
REQ-019 Count latency SHALL be one clock: the new value is visible on q after the enabling edge.
REQ-020 up SHALL be sampled every cycle; a direction change takes effect on the same edge, with no dead cycle.
REQ-021 tc SHALL be 1 when en=1 and q is all digits MODULUS-1 (up=1) or all digits 0 (up=0); otherwise 0.
REQ-022 SATURATE=0: when tc=1 and load=0, the next edge SHALL wrap q to all 0 (up) or all MODULUS-1 (down).
REQ-023 SATURATE=0: wrap SHALL be 1 for exactly the cycle following each wrap edge.
REQ-024 SATURATE=1: when tc=1 and load=0, q SHALL hold.
REQ-025 SATURATE=1: wrap SHALL be 1 in the cycle after each blocked count.
REQ-026 Back-to-back wrap or blocked events SHALL produce wrap high on consecutive cycles.
REQ-027 Digits SHALL never hold a value >= MODULUS under any input sequence.
REQ-028 tc SHALL be usable as the en input of a further instance, so cascaded instances count as one wider counter.

Reset
REQ-029 clear=1 at an edge SHALL set q to all 0 and wrap to 0, overriding load and en, including mid-count or mid-load.
REQ-030 After clear deasserts, counting SHALL resume on the first edge with en=1, with no extra latency.
REQ-031 No state SHALL change except on a rising clk edge; there is no asynchronous path.

Verification (WIDTH=4, MODULUS=10, DIGITS=2 unless stated)
REQ-032 clear, then en=1 up=1 for 100 cycles -> q steps 0x00..0x09, 0x10..0x99; tc=1 at 0x99; q=0x00 next, with wrap=1 for one cycle.
REQ-033 clear, then en=1 up=0 -> q = 0x99 after the first edge with wrap=1, then 0x98, 0x97, ...; 0x90 -> 0x89.
REQ-034 load=1 load_val=0x3F -> q=0x39; load=1 with en=1 and load_val=0x52 -> q=0x52, no step; clear=1 with load=1 -> q=0x00.
REQ-035 SATURATE=1, q=0x99, en=1 up=1 for 3 cycles -> q stays 0x99, tc=1, wrap=1 on 3 consecutive cycles; switch up=0 -> 0x98.
REQ-036 q=0x45, en=1: up=1 one cycle then up=0 one cycle -> 0x46 then 0x45; en=0 -> q holds 0x45, tc=0.
REQ-037 Two instances chained (first tc -> second en), MODULUS=6, DIGITS=1 each -> combined count cycles 0..35 and wraps.
